player_renderer: RTL and testbench

Pixel-colour source for the VGA path: consumes the `x`/`y` scan coordinates from `video_driver` and returns registered `r`/`g`/`b` for every pixel. Holds the player's grid position, which is moved one cell per frame from debounced-free edge-detected `KEY` presses. Draws a goal row, road rows and the player cell. Sits directly upstream of `video_driver`'s colour inputs in `DE1_SoC`.

---
 rtl/player_renderer_if.sv | 26 ++
 rtl/player_renderer.sv | 138 +++++++++++++
 tb/tb_player_renderer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_renderer_if.sv
// player_renderer_if
// Groups the pixel-scan, push-button and colour/position signals exchanged
// between the renderer and its surroundings (video_driver, board keys).
//   master : drives x, y, KEY; observes r, g, b, player_col, player_row, win
//   slave  : the renderer itself
interface player_renderer_if;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] KEY;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [4:0] player_col;
    logic [3:0] player_row;
    logic       win;

    modport master (
        output x, y, KEY,
        input  r, g, b, player_col, player_row, win
    );

    modport slave (
        input  x, y, KEY,
        output r, g, b, player_col, player_row, win
    );
endinterface

// File: rtl/player_renderer.sv
// player_renderer
// Pixel-colour source for the VGA path. Holds the player's grid position,
// moves it at most one cell per frame from edge-detected key presses, and
// returns a registered colour for every scan coordinate.
// Ports:
//   CLOCK_50 : system clock, all state on rising edge
//   reset    : asynchronous, active-high reset
//   bus      : slave side of player_renderer_if
//              x/y scan position, KEY (active-low: [3] left, [2] up,
//              [1] down, [0] right), r/g/b colour (1 clock after x/y),
//              player_col/player_row position, win (sticky)
module player_renderer #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int CELL_LOG2 = 5
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    player_renderer_if.slave    bus
);

    localparam int GRID_W = WIDTH >> CELL_LOG2;
    localparam int GRID_H = HEIGHT >> CELL_LOG2;

    localparam logic [9:0] X_LIM     = 10'(WIDTH);
    localparam logic [8:0] Y_LIM     = 9'(HEIGHT);
    localparam logic [9:0] X_LAST    = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST    = 9'(HEIGHT - 1);
    localparam logic [4:0] COL_MAX   = 5'(GRID_W - 1);
    localparam logic [3:0] ROW_MAX   = 4'(GRID_H - 1);
    localparam logic [4:0] COL_START = 5'(GRID_W / 2);

    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_BLUE   = 24'h0000FF;
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] C_GOAL   = 24'h00C800;
    localparam logic [23:0] C_START  = 24'h808080;
    localparam logic [23:0] C_ROAD   = 24'h404040;
    localparam logic [23:0] C_STRIPE = 24'hFFFF00;

    // Key bit positions within KEY / pending
    localparam int K_RIGHT = 0;
    localparam int K_DOWN  = 1;
    localparam int K_UP    = 2;
    localparam int K_LEFT  = 3;

    logic [3:0]  sync1_q, sync2_q, sync3_q;
    logic [3:0]  press_q;
    logic [3:0]  pending_q, pending_d;
    logic        eof_q, eof_prev_q, tick;
    logic [4:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic        win_q, win_d;
    logic [23:0] rgb_q, rgb_d;
    logic [4:0]  pix_col;
    logic [3:0]  pix_row;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            sync3_q    <= '1;
            press_q    <= '0;
            pending_q  <= '0;
            eof_q      <= 1'b0;
            eof_prev_q <= 1'b0;
            col_q      <= COL_START;
            row_q      <= ROW_MAX;
            win_q      <= 1'b0;
            rgb_q      <= C_BLACK;
        end else begin
            sync1_q    <= bus.KEY;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            // Synchronized 1->0 transition; holding a key yields one pulse.
            press_q    <= sync3_q & ~sync2_q;
            pending_q  <= pending_d;
            eof_q      <= (bus.x == X_LAST) && (bus.y == Y_LAST);
            eof_prev_q <= eof_q;
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            rgb_q      <= rgb_d;
        end
    end

    // One pulse per frame no matter how long x/y sit on the last pixel.
    assign tick = eof_q & ~eof_prev_q;

    // A press arriving on the tick cycle survives the clear and waits a frame.
    assign pending_d = tick ? press_q : (pending_q | press_q);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        if (tick && !win_q) begin
            if (pending_q[K_UP]) begin
                if (row_q != 4'd0) row_d = row_q - 4'd1;
            end else if (pending_q[K_DOWN]) begin
                if (row_q != ROW_MAX) row_d = row_q + 4'd1;
            end else if (pending_q[K_LEFT]) begin
                if (col_q != 5'd0) col_d = col_q - 5'd1;
            end else if (pending_q[K_RIGHT]) begin
                if (col_q != COL_MAX) col_d = col_q + 5'd1;
            end
        end
        if (row_d == 4'd0) win_d = 1'b1;
    end

    assign pix_col = 5'(bus.x >> CELL_LOG2);
    assign pix_row = 4'(bus.y >> CELL_LOG2);

    always_comb begin
        rgb_d = C_BLACK;
        if (bus.x >= X_LIM || bus.y >= Y_LIM) begin
            rgb_d = C_BLACK;
        end else if (pix_col == col_q && pix_row == row_q) begin
            rgb_d = win_q ? C_WHITE : C_BLUE;
        end else if (pix_row == 4'd0) begin
            rgb_d = C_GOAL;
        end else if (pix_row == ROW_MAX) begin
            rgb_d = C_START;
        end else if (bus.y[CELL_LOG2-1:0] == '0) begin
            rgb_d = C_STRIPE;
        end else begin
            rgb_d = C_ROAD;
        end
    end

    assign bus.r          = rgb_q[23:16];
    assign bus.g          = rgb_q[15:8];
    assign bus.b          = rgb_q[7:0];
    assign bus.player_col = col_q;
    assign bus.player_row = row_q;
    assign bus.win        = win_q;

endmodule

// File: tb/tb_player_renderer.sv
// tb_player_renderer
// Self-checking bench for player_renderer: drives scan coordinates and keys
// through the interface and compares position, win and colour against a
// grid-level reference model kept here.
module tb_player_renderer;

    logic clk = 1'b0;
    logic rst;

    player_renderer_if bus();

    player_renderer dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int         m_col;
    int         m_row;
    bit         m_win;
    logic [3:0] m_pend;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic model_reset();
        m_col  = 10;
        m_row  = 14;
        m_win  = 1'b0;
        m_pend = 4'b0000;
    endtask

    // One frame: at most one move, up > down > left > right, clamped to grid.
    task automatic model_tick(input logic [3:0] pend);
        if (!m_win) begin
            if (pend[2])      m_row = (m_row > 0)  ? m_row - 1 : m_row;
            else if (pend[1]) m_row = (m_row < 14) ? m_row + 1 : m_row;
            else if (pend[3]) m_col = (m_col > 0)  ? m_col - 1 : m_col;
            else if (pend[0]) m_col = (m_col < 19) ? m_col + 1 : m_col;
        end
        if (m_row == 0) m_win = 1'b1;
    endtask

    function automatic logic [23:0] exp_rgb(input int px, input int py);
        int c;
        int rw;
        c  = px / 32;
        rw = py / 32;
        if (px >= 640 || py >= 480)        return 24'h000000;
        if (c == m_col && rw == m_row)     return m_win ? 24'hFFFFFF : 24'h0000FF;
        if (rw == 0)                       return 24'h00C800;
        if (rw == 14)                      return 24'h808080;
        if (py % 32 == 0)                  return 24'hFFFF00;
        return 24'h404040;
    endfunction

    // Press the keys in mask (active-high here), long enough to be seen.
    task automatic press_keys(input logic [3:0] mask);
        bus.KEY = ~mask;
        steps(10);
        bus.KEY = 4'hF;
        steps(4);
        m_pend = m_pend | mask;
    endtask

    // Park the scan on the last active pixel for hold clocks, then leave.
    task automatic run_frame(input int hold);
        bus.x = 10'd639;
        bus.y = 9'd479;
        steps(hold);
        bus.x = 10'd0;
        bus.y = 9'd0;
        step();
        model_tick(m_pend);
        m_pend = 4'b0000;
        step();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.KEY = 4'hF;
        bus.x   = 10'd0;
        bus.y   = 9'd0;
        steps(3);
        model_reset();
        checks++;
        if ({bus.player_col, bus.player_row, bus.win} !== {5'd10, 4'd14, 1'b0}) begin
            failures++;
            $display("FAIL reset_pos: got col=%0d row=%0d win=%0d expected col=10 row=14 win=0",
                     bus.player_col, bus.player_row, bus.win);
        end
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_rgb: got %h expected 000000", {bus.r, bus.g, bus.b});
        end
        rst   = 1'b0;
        bus.x = 10'd5;
        bus.y = 9'd100;
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h404040) begin
            failures++;
            $display("FAIL road_pixel: got %h expected 404040", {bus.r, bus.g, bus.b});
        end
        bus.y = 9'd96;
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'hFFFF00) begin
            failures++;
            $display("FAIL stripe_pixel: got %h expected ffff00", {bus.r, bus.g, bus.b});
        end
    endtask

    task automatic test_move_up();
        press_keys(4'b0100);
        run_frame(1);
        checks++;
        if ({bus.player_col, bus.player_row, bus.win} !== {5'd10, 4'd13, 1'b0}) begin
            failures++;
            $display("FAIL move_up: got col=%0d row=%0d win=%0d expected col=10 row=13 win=0",
                     bus.player_col, bus.player_row, bus.win);
        end
        run_frame(3);
        checks++;
        if ({bus.player_col, bus.player_row} !== {5'(m_col), 4'(m_row)}) begin
            failures++;
            $display("FAIL move_up_once: got col=%0d row=%0d expected col=%0d row=%0d",
                     bus.player_col, bus.player_row, m_col, m_row);
        end
        bus.x = 10'd330;
        bus.y = 9'd420;
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h0000FF) begin
            failures++;
            $display("FAIL player_blue: got %h expected 0000ff", {bus.r, bus.g, bus.b});
        end
    endtask

    task automatic test_priority();
        press_keys(4'b1100);
        run_frame(2);
        checks++;
        if ({bus.player_col, bus.player_row, bus.win} !== {5'(m_col), 4'(m_row), m_win}) begin
            failures++;
            $display("FAIL priority: got col=%0d row=%0d win=%0d expected col=%0d row=%0d win=%0d",
                     bus.player_col, bus.player_row, bus.win, m_col, m_row, m_win);
        end
    endtask

    task automatic test_press_on_tick();
        // Key falls now; its press pulse lands on the same cycle as tick.
        bus.KEY = 4'b1011;
        steps(2);
        bus.x = 10'd639;
        bus.y = 9'd479;
        steps(2);
        model_tick(4'b0000);
        checks++;
        if ({bus.player_col, bus.player_row} !== {5'(m_col), 4'(m_row)}) begin
            failures++;
            $display("FAIL press_on_tick_held: got col=%0d row=%0d expected col=%0d row=%0d",
                     bus.player_col, bus.player_row, m_col, m_row);
        end
        m_pend  = 4'b0100;
        bus.x   = 10'd0;
        bus.y   = 9'd0;
        steps(4);
        bus.KEY = 4'hF;
        steps(4);
        run_frame(1);
        checks++;
        if ({bus.player_col, bus.player_row} !== {5'(m_col), 4'(m_row)}) begin
            failures++;
            $display("FAIL press_on_tick_next: got col=%0d row=%0d expected col=%0d row=%0d",
                     bus.player_col, bus.player_row, m_col, m_row);
        end
    endtask

    task automatic test_clamp_right();
        for (int i = 0; i < 11; i++) begin
            press_keys(4'b0001);
            run_frame(1);
            checks++;
            if (bus.player_col !== 5'(m_col)) begin
                failures++;
                $display("FAIL clamp_right_%0d: got col=%0d expected col=%0d",
                         i, bus.player_col, m_col);
            end
        end
        checks++;
        if (bus.player_col !== 5'd19) begin
            failures++;
            $display("FAIL clamp_right_sat: got col=%0d expected col=19", bus.player_col);
        end
    endtask

    task automatic test_random_moves();
        int px;
        int py;
        logic [3:0] mask;
        for (int i = 0; i < 14; i++) begin
            mask = 4'($urandom_range(1, 15));
            press_keys(mask);
            run_frame($urandom_range(1, 5));
            checks++;
            if ({bus.player_col, bus.player_row, bus.win} !== {5'(m_col), 4'(m_row), m_win}) begin
                failures++;
                $display("FAIL rand_move_%0d: keys=%b got col=%0d row=%0d win=%0d expected col=%0d row=%0d win=%0d",
                         i, mask, bus.player_col, bus.player_row, bus.win, m_col, m_row, m_win);
            end
            if (i % 2 == 0) begin
                px = m_col * 32 + int'($urandom_range(0, 31));
                py = m_row * 32 + int'($urandom_range(0, 31));
            end else begin
                px = int'($urandom_range(0, 799));
                py = int'($urandom_range(0, 511));
            end
            bus.x = 10'(px);
            bus.y = 9'(py);
            step();
            checks++;
            if ({bus.r, bus.g, bus.b} !== exp_rgb(px, py)) begin
                failures++;
                $display("FAIL rand_pixel_%0d: (%0d,%0d) got %h expected %h",
                         i, px, py, {bus.r, bus.g, bus.b}, exp_rgb(px, py));
            end
        end
        bus.x = 10'd0;
        bus.y = 9'd0;
        step();
    endtask

    task automatic test_blanking();
        bus.x = 10'd700;
        bus.y = 9'd100;
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h000000) begin
            failures++;
            $display("FAIL blank_pixel: got %h expected 000000", {bus.r, bus.g, bus.b});
        end
        // A left press arrives while the scan is still parked on the last
        // pixel; only one tick may occur, so it must wait for the next frame.
        bus.KEY = 4'b0111;
        bus.x   = 10'd639;
        bus.y   = 9'd479;
        steps(8);
        model_tick(4'b0000);
        checks++;
        if ({bus.player_col, bus.player_row} !== {5'(m_col), 4'(m_row)}) begin
            failures++;
            $display("FAIL single_tick: got col=%0d row=%0d expected col=%0d row=%0d",
                     bus.player_col, bus.player_row, m_col, m_row);
        end
        m_pend  = 4'b1000;
        bus.x   = 10'd0;
        bus.y   = 9'd0;
        bus.KEY = 4'hF;
        steps(3);
        run_frame(5);
        checks++;
        if ({bus.player_col, bus.player_row} !== {5'(m_col), 4'(m_row)}) begin
            failures++;
            $display("FAIL held_left_applied: got col=%0d row=%0d expected col=%0d row=%0d",
                     bus.player_col, bus.player_row, m_col, m_row);
        end
    endtask

    task automatic test_win();
        int px;
        int py;
        for (int i = 0; i < 20 && !m_win; i++) begin
            press_keys(4'b0100);
            run_frame(1);
            checks++;
            if ({bus.player_row, bus.win} !== {4'(m_row), m_win}) begin
                failures++;
                $display("FAIL win_climb_%0d: got row=%0d win=%0d expected row=%0d win=%0d",
                         i, bus.player_row, bus.win, m_row, m_win);
            end
        end
        checks++;
        if ({bus.player_row, bus.win} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL win_set: got row=%0d win=%0d expected row=0 win=1",
                     bus.player_row, bus.win);
        end
        px = m_col * 32 + 5;
        py = 10;
        bus.x = 10'(px);
        bus.y = 9'(py);
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL win_white: got %h expected ffffff", {bus.r, bus.g, bus.b});
        end
        press_keys(4'b0010);
        run_frame(1);
        checks++;
        if ({bus.player_col, bus.player_row, bus.win} !== {5'(m_col), 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL win_frozen: got col=%0d row=%0d win=%0d expected col=%0d row=0 win=1",
                     bus.player_col, bus.player_row, bus.win, m_col);
        end
    endtask

    task automatic test_reset_mid();
        bus.x = 10'd330;
        bus.y = 9'd10;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bus.player_col, bus.player_row, bus.win} !== {5'd10, 4'd14, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_pos: got col=%0d row=%0d win=%0d expected col=10 row=14 win=0",
                     bus.player_col, bus.player_row, bus.win);
        end
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_mid_rgb: got %h expected 000000", {bus.r, bus.g, bus.b});
        end
        steps(2);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_release_rgb: got %h expected 000000", {bus.r, bus.g, bus.b});
        end
        step();
        checks++;
        if ({bus.r, bus.g, bus.b} !== exp_rgb(330, 10)) begin
            failures++;
            $display("FAIL reset_first_pixel: got %h expected %h",
                     {bus.r, bus.g, bus.b}, exp_rgb(330, 10));
        end
    endtask

    initial begin
        test_reset();
        test_move_up();
        test_priority();
        test_press_on_tick();
        test_clamp_right();
        test_random_moves();
        test_blanking();
        test_win();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
